// File: rtl/muldiv_unit.sv
// muldiv_unit
//   Iterative radix-2 multiply/divide unit with HI/LO result registers.
//   Handles MULT, MULTU, DIV, DIVU (one bit per clock, fixed latency)
//   and MTHI/MTLO writes. Sits beside the ALU; busy_o stalls the pipe.
//
// Ports
//   clk_i     clock, rising edge
//   rst_i     asynchronous active-high reset
//   start_i   launch an operation (ignored while busy or flushing)
//   op_i      00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   src1_i    multiplicand / dividend
//   src2_i    multiplier / divisor
//   flush_i   kill the in-flight operation
//   hi_we_i   MTHI write enable
//   lo_we_i   MTLO write enable
//   wdata_i   MTHI/MTLO write data
//   busy_o    operation in flight (CALC or FIX)
//   done_o    one-cycle pulse when HI/LO hold a new result
//   hi_o      HI register (product upper half / remainder)
//   lo_o      LO register (product lower half / quotient)
module muldiv_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] src1_i,
  input  logic [WIDTH-1:0] src2_i,
  input  logic             flush_i,
  input  logic             hi_we_i,
  input  logic             lo_we_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             isDiv_q;
  logic             negLo_q;
  logic             negHi_q;
  logic             divZero_q;
  logic [WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] mq_q;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;

  logic             idleLike;
  logic             startAccept;
  logic             s1Neg;
  logic             s2Neg;
  logic [WIDTH-1:0] mag1;
  logic [WIDTH-1:0] mag2;

  // Only IDLE and DONE can accept work; flush always beats a new start.
  assign idleLike    = (state_q == IDLE) || (state_q == DONE);
  assign startAccept = idleLike && start_i && !flush_i;

  // Signed ops work on magnitudes; the most-negative value maps to
  // 2**(WIDTH-1), which still fits as an unsigned WIDTH-bit number.
  assign s1Neg = src1_i[WIDTH-1] & ~op_i[0];
  assign s2Neg = src2_i[WIDTH-1] & ~op_i[0];
  assign mag1  = s1Neg ? -src1_i : src1_i;
  assign mag2  = s2Neg ? -src2_i : src2_i;

  logic [WIDTH:0]   addSum;
  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] trial;
  logic [WIDTH-1:0] accStep_d;
  logic [WIDTH-1:0] mqStep_d;

  // One iteration. Multiply: {acc,mq} is the product shifter, mq's LSB
  // selects the add. Divide: acc is the partial remainder, mq shifts the
  // dividend out at the top and the quotient in at the bottom. Since the
  // remainder stays below the divisor, the subtraction fits in WIDTH bits.
  always_comb begin
    addSum    = {1'b0, acc_q} + {1'b0, mcand_q};
    shifted   = {acc_q, mq_q[WIDTH-1]};
    trial     = shifted[WIDTH-1:0] - mcand_q;
    accStep_d = acc_q;
    mqStep_d  = mq_q;
    if (isDiv_q) begin
      if (shifted >= {1'b0, mcand_q}) begin
        accStep_d = trial;
        mqStep_d  = {mq_q[WIDTH-2:0], 1'b1};
      end else begin
        accStep_d = shifted[WIDTH-1:0];
        mqStep_d  = {mq_q[WIDTH-2:0], 1'b0};
      end
    end else if (mq_q[0]) begin
      accStep_d = addSum[WIDTH:1];
      mqStep_d  = {addSum[0], mq_q[WIDTH-1:1]};
    end else begin
      accStep_d = {1'b0, acc_q[WIDTH-1:1]};
      mqStep_d  = {acc_q[0], mq_q[WIDTH-1:1]};
    end
  end

  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   fixHi_d;
  logic [WIDTH-1:0]   fixLo_d;

  // Sign fix-up. With a zero divisor the remainder path has shifted the
  // whole dividend magnitude into acc, so re-applying the dividend sign
  // reproduces src1 exactly. MIN/-1 needs no special case: the quotient
  // magnitude 2**(WIDTH-1) negates back to MIN and the remainder is 0.
  always_comb begin
    prod    = {acc_q, mq_q};
    fixHi_d = negHi_q ? -acc_q : acc_q;
    fixLo_d = negLo_q ? -mq_q : mq_q;
    if (!isDiv_q) begin
      {fixHi_d, fixLo_d} = negLo_q ? -prod : prod;
    end else if (divZero_q) begin
      fixLo_d = {WIDTH{1'b1}};
    end
  end

  // Main FSM: operand latch, iteration, fix-up and MTHI/MTLO writes.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      isDiv_q   <= 1'b0;
      negLo_q   <= 1'b0;
      negHi_q   <= 1'b0;
      divZero_q <= 1'b0;
      mcand_q   <= '0;
      acc_q     <= '0;
      mq_q      <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (startAccept) begin
            state_q   <= CALC;
            cnt_q     <= '0;
            isDiv_q   <= op_i[1];
            negLo_q   <= s1Neg ^ s2Neg;
            negHi_q   <= s1Neg;
            divZero_q <= (src2_i == '0);
            acc_q     <= '0;
            mcand_q   <= op_i[1] ? mag2 : mag1;
            mq_q      <= op_i[1] ? mag1 : mag2;
          end else begin
            state_q <= IDLE;
          end
          if (!start_i) begin
            if (hi_we_i) hi_q <= wdata_i;
            if (lo_we_i) lo_q <= wdata_i;
          end
        end
        CALC: begin
          if (flush_i) begin
            state_q <= IDLE;
          end else begin
            acc_q <= accStep_d;
            mq_q  <= mqStep_d;
            cnt_q <= cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(WIDTH - 1)) state_q <= FIX;
          end
        end
        FIX: begin
          if (flush_i) begin
            state_q <= IDLE;
          end else begin
            hi_q    <= fixHi_d;
            lo_q    <= fixLo_d;
            state_q <= DONE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy_o = (state_q == CALC) || (state_q == FIX);
  assign done_o = (state_q == DONE);
  assign hi_o   = hi_q;
  assign lo_o   = lo_q;

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Parametrised iterative multiply/divide unit with HI/LO result registers for the next CPU generation.
- Supports MULT, MULTU, DIV and DIVU, plus MTHI/MTLO writes.
- Sits beside the ALU in the execute stage. Its busy_o stalls the pipeline while an operation is in flight; flush_i kills an operation belonging to a squashed instruction.
- Radix-2, one bit per clock, fixed latency for all opcodes.

Parameters:
- WIDTH, 32, operand width in bits; HI and LO are each WIDTH bits; must be >= 4 and even.
- CNT_W, 6, iteration counter width; must satisfy 2**CNT_W > WIDTH.

Ports:
- clk_i  input  1  clock; all state changes on rising edge.
- rst_i  input  1  asynchronous, active-high reset.
- start_i  input  1  request an operation; sampled only when not busy.
- op_i  input  2  00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU; sampled with start_i.
- src1_i  input  WIDTH  multiplicand / dividend; sampled with start_i.
- src2_i  input  WIDTH  multiplier / divisor; sampled with start_i.
- flush_i  input  1  abort the in-flight operation.
- hi_we_i  input  1  MTHI write enable.
- lo_we_i  input  1  MTLO write enable.
- wdata_i  input  WIDTH  MTHI/MTLO write data.
- busy_o  output  1  operation in flight; pipeline must stall MFHI/MFLO and new mul/div.
- done_o  output  1  one-cycle pulse when HI/LO hold a new result.
- hi_o  output  WIDTH  HI register (multiply upper half / remainder).
- lo_o  output  WIDTH  LO register (multiply lower half / quotient).

Behaviour:
- Reset (async, any time, including mid-operation):
  - state=IDLE; hi_o=0, lo_o=0, busy_o=0, done_o=0; counter=0.
  - Any partial result is discarded.
- States: IDLE, CALC, FIX, DONE.
- IDLE/DONE with start_i=1 at edge N:
  - Latch op and operands.
  - Signed ops: convert operands to magnitudes; record the result signs (product sign = s1^s2; quotient sign = s1^s2; remainder sign = s1).
  - Go to CALC with counter=0.
- CALC:
  - One shift-add (multiply) or restoring shift-subtract (divide) step per edge.
  - Counter increments each edge. After WIDTH edges in CALC, go to FIX.
- FIX (one edge):
  - Apply two's-complement negation per the recorded signs.
  - Write hi_o/lo_o; go to DONE.
- DONE:
  - done_o=1 for exactly this cycle.
  - Next edge goes to IDLE, or straight to CALC if start_i=1.
- Outputs and latency:
  - busy_o=1 exactly while in CALC or FIX; 0 in IDLE and DONE.
  - Latency: start sampled at edge N → hi/lo updated and done_o high after edge N+WIDTH+1.
  - busy_o is high for WIDTH+1 cycles.
- Result rules:
  - Multiply: {hi_o,lo_o} = full 2*WIDTH-bit product, exact, no overflow.
  - Divide: quotient truncates toward zero.
  - Signed overflow (most-negative / -1): lo_o = most-negative, hi_o = 0.
  - Divide by zero (any divide op): lo_o = all ones, hi_o = src1 unmodified. Same latency; no exception.
- start_i while busy_o=1: ignored, no queuing.
- flush_i:
  - In CALC or FIX: next edge goes to IDLE; hi_o/lo_o keep their prior values; done_o stays 0.
  - In IDLE/DONE: a simultaneous start_i is ignored (flush wins).
- hi_we_i / lo_we_i:
  - Take effect at the edge only when busy_o=0 and start_i=0; otherwise ignored.
  - Both may be asserted together; each writes wdata_i to its own register.
  - A write in the DONE cycle overrides the just-produced value.
- HI/LO never change except at reset, at the FIX→DONE edge, or through accepted MTHI/MTLO writes.

Test Plan:
- Reset then MULTU src1=0xFFFFFFFF, src2=0xFFFFFFFF:
  - busy_o high 33 cycles; done_o pulses once 33 cycles after start.
  - hi_o=0xFFFFFFFE, lo_o=0x00000001.
- MULT src1=0xFFFFFFFD (-3), src2=7 → hi_o=0xFFFFFFFF, lo_o=0xFFFFFFEB (-21). DIV src1=-7, src2=2 → lo_o=0xFFFFFFFD (-3), hi_o=0xFFFFFFFF (-1).
- Boundary divides:
  - DIVU src1=100, src2=0 → lo_o=0xFFFFFFFF, hi_o=100.
  - DIV src1=0x80000000, src2=0xFFFFFFFF → lo_o=0x80000000, hi_o=0.
- Abort and ignored start:
  - Preload hi=0x11, lo=0x22 via MTHI/MTLO. Start DIVU 50/7; assert flush_i at cycle 10 → IDLE next edge, no done_o, hi_o=0x11, lo_o=0x22.
  - start_i pulsed mid-CALC is ignored.
- Back-to-back operations:
  - start_i held in the DONE cycle of MULTU 3*5 (lo=15) launches DIVU 15/4 without an IDLE gap → lo_o=3, hi_o=3.
  - MTLO with wdata_i=0xAA while busy is ignored.
- Assert rst_i asynchronously mid-CALC (between clock edges) → busy_o, done_o, hi_o, lo_o read 0 immediately; the next start_i after release completes normally.
